// File: rtl/memory_writeback_stage_if.sv
// Bus between EXECUTE and the memory/writeback stage: XM_* come from
// upstream, MW_* plus stall/misalign go back out.
interface memory_writeback_stage_if;
    logic [31:0] XM_ALUout;
    logic [31:0] XM_B;
    logic [4:0]  XM_RD;
    logic        XM_MemRead;
    logic        XM_MemWrite;
    logic [31:0] MW_ALUout;
    logic [4:0]  MW_RD;
    logic        stall;
    logic        misalign;

    modport master (
        output XM_ALUout, XM_B, XM_RD, XM_MemRead, XM_MemWrite,
        input  MW_ALUout, MW_RD, stall, misalign
    );

    modport slave (
        input  XM_ALUout, XM_B, XM_RD, XM_MemRead, XM_MemWrite,
        output MW_ALUout, MW_RD, stall, misalign
    );
endinterface

// File: rtl/memory_writeback_stage.sv
// MEM/WB stage of the 5-stage MIPS pipe: owns the word-addressed data
// memory, runs lw/sw with WAIT_CYCLES wait states, stalls upstream and
// emits bubbles (MW_RD = 0) while an access is in flight.
// Optional macro DMEM_MISALIGN_CHECK_EN: suppress misaligned accesses at
// completion and pulse misalign; otherwise address bits [1:0] are ignored.
module memory_writeback_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    memory_writeback_stage_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mw_aluout_q, mw_aluout_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic        misalign_q, misalign_d;

    logic [31:0] mem [0:DEPTH-1];

    logic              memop;
    logic              complete;
    logic              mem_we;
    logic              stall_c;
    logic              misal;
    logic [ADDR_W-1:0] addr;
    logic              unused_addr_bits;

    assign memop = bus.XM_MemRead | bus.XM_MemWrite;
    assign addr  = bus.XM_ALUout[ADDR_W+1:2];
    // upper address bits wrap away; low bits only matter for the misalign check
    assign unused_addr_bits = ^{bus.XM_ALUout[31:ADDR_W+2], bus.XM_ALUout[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misal = (bus.XM_ALUout[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Next-state, writeback and stall decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mw_aluout_d = mw_aluout_q;
        mw_rd_d     = mw_rd_q;
        misalign_d  = 1'b0;
        complete    = 1'b0;
        mem_we      = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!memop) begin
                    mw_aluout_d = bus.XM_ALUout;
                    mw_rd_d     = bus.XM_RD;
                end else if (WAIT_CYCLES == 0) begin
                    complete = 1'b1;
                end else begin
                    cnt_d   = CNT_INIT;
                    mw_rd_d = 5'd0;
                    state_d = WAIT;
                    stall_c = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    mw_rd_d = 5'd0;
                    stall_c = 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion: store wins when both read and write are asserted
        if (complete) begin
            if (misal) begin
                mw_aluout_d = bus.XM_ALUout;
                mw_rd_d     = 5'd0;
                misalign_d  = 1'b1;
            end else if (bus.XM_MemWrite) begin
                mem_we      = !rst;
                mw_aluout_d = bus.XM_ALUout;
                mw_rd_d     = 5'd0;
            end else begin
                mw_aluout_d = mem[addr];
                mw_rd_d     = bus.XM_RD;
            end
        end
    end

    // Pipeline and FSM registers; reset drops any pending access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mw_aluout_q <= 32'd0;
            mw_rd_q     <= 5'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mw_aluout_q <= mw_aluout_d;
            mw_rd_q     <= mw_rd_d;
            misalign_q  <= misalign_d;
        end
    end

    // Data memory: not reset, written only on a store's completion edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= bus.XM_B;
        end
    end

    assign bus.MW_ALUout = mw_aluout_q;
    assign bus.MW_RD     = mw_rd_q;
    assign bus.stall     = stall_c;
    assign bus.misalign  = misalign_q;
endmodule
